// File: rtl/clm_mixcol_addkey_stage_pkg.sv
// Shared types for the CLM MixColumns/AddRoundKey back-end: masked byte, column, state,
// randomness vector, CLM matrices and the stage FSM encoding.
package clm_mixcol_addkey_stage_pkg;

  localparam int D           = 1;
  localparam int NSH         = D + 1;
  localparam int MC_NUM_COLS = 4;
  localparam int MC_NUM_ROWS = 4;
  localparam int MC_RAND_N   = 16;

  typedef logic [7:0]                          red_poly_t;
  // A masked byte is NSH shares whose XOR is the clear value.
  typedef red_poly_t   [NSH-1:0]               state_t;
  typedef state_t      [0:MC_NUM_ROWS-1]       state_word_t;
  typedef state_word_t [0:MC_NUM_COLS-1]       state_matrix_t;
  typedef red_poly_t   [0:MC_RAND_N-1]         rand_vect_t;

  typedef logic [7:0][7:0]                     mm_matrix_t;
  typedef logic [NSH-1:0][1:0]                 mc_m_matrix_t;
  typedef logic [NSH-1:0][1:0]                 mn_matrix_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } mc_stage_state_t;

  // GF(2) matrix-vector product; row r of m selects the input bits feeding output bit r.
  function automatic red_poly_t gf_mat_mul(input mm_matrix_t m, input red_poly_t x);
    red_poly_t y;
    for (int r = 0; r < 8; r++) y[r] = ^(m[r] & x);
    return y;
  endfunction

endpackage

// File: rtl/clm_mixcol_addkey_stage_mix_column_single.sv
// One masked MixColumns column, share-wise, with refresh masks drawn from random_vect.
module mix_column_single
  import clm_mixcol_addkey_stage_pkg::*;
#(
  parameter int d = D
) (
  input  state_word_t  col_in,
  input  rand_vect_t   random_vect,
  input  mm_matrix_t   L,
  input  mc_m_matrix_t B_ext_MC,
  input  mn_matrix_t   MC,
  output state_word_t  col_out
);

  localparam int NS = d + 1;

  // Row r: 2*(a_r ^ a_r+1) ^ a_r+1 ^ a_r+2 ^ a_r+3, evaluated per share. Each random byte
  // lands on the shares selected by a matrix column; even-weight columns cancel on decode.
  for (genvar r = 0; r < MC_NUM_ROWS; r++) begin : g_row
    for (genvar s = 0; s < NS; s++) begin : g_sh
      red_poly_t t_sh, m2, m1;
      assign t_sh = col_in[r][s] ^ col_in[(r+1)%4][s];
      assign m2   = (B_ext_MC[s][0] ? random_vect[4*r]   : 8'h00)
                  ^ (B_ext_MC[s][1] ? random_vect[4*r+1] : 8'h00);
      assign m1   = (MC[s][0]       ? random_vect[4*r+2] : 8'h00)
                  ^ (MC[s][1]       ? random_vect[4*r+3] : 8'h00);
      assign col_out[r][s] = gf_mat_mul(L, t_sh) ^ m2
                           ^ col_in[(r+1)%4][s] ^ col_in[(r+2)%4][s] ^ col_in[(r+3)%4][s] ^ m1;
    end
  end

endmodule

// File: rtl/clm_mixcol_addkey_stage.sv
// Column-serial masked MixColumns + AddRoundKey stage (one column per cycle, one datapath).
// CLM_MC_LAST_ROUND_EN adds a latched last_round input that bypasses MixColumns.
module clm_mixcol_addkey_stage
  import clm_mixcol_addkey_stage_pkg::*;
#(
  parameter int d = D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  state_matrix_t in_state,
  input  state_matrix_t in_key,
`ifdef CLM_MC_LAST_ROUND_EN
  input  logic          last_round,
`endif
  input  rand_vect_t    random_vect,
  output logic          rand_req,
  input  mm_matrix_t    L,
  input  mc_m_matrix_t  B_ext_MC,
  input  mn_matrix_t    MC,
  output logic          out_valid,
  input  logic          out_ready,
  output state_matrix_t out_state
);

  mc_stage_state_t state_q, state_d;
  logic [1:0]      col_cnt_q, col_cnt_d;
  state_matrix_t   state_reg_q, state_reg_d;
  state_matrix_t   key_reg_q, key_reg_d;
  state_matrix_t   res_reg_q, res_reg_d;
  state_word_t     mix_col, mc_out, col_res;
  logic            bypass;

`ifdef CLM_MC_LAST_ROUND_EN
  logic last_q, last_d;
  assign bypass = last_q;
`else
  assign bypass = 1'b0;
`endif

  assign mix_col = state_reg_q[col_cnt_q];

  mix_column_single #(.d(d)) u_mix (
    .col_in      (mix_col),
    .random_vect (random_vect),
    .L           (L),
    .B_ext_MC    (B_ext_MC),
    .MC          (MC),
    .col_out     (mc_out)
  );

  // Masking is share-wise XOR, so the key add needs no refresh.
  assign col_res = (bypass ? mix_col : mc_out) ^ key_reg_q[col_cnt_q];

  assign in_ready  = rst_n && (state_q == IDLE);
  assign rand_req  = (state_q == MIX) && !bypass;
  assign out_valid = (state_q == DONE);
  assign out_state = res_reg_q;

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    state_reg_d = state_reg_q;
    key_reg_d   = key_reg_q;
    res_reg_d   = res_reg_q;
`ifdef CLM_MC_LAST_ROUND_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_reg_d = in_state;
          key_reg_d   = in_key;
          col_cnt_d   = 2'd0;
`ifdef CLM_MC_LAST_ROUND_EN
          last_d      = last_round;
`endif
          state_d     = MIX;
        end
      end
      MIX: begin
        res_reg_d[col_cnt_q] = col_res;
        if (col_cnt_q == 2'd3) state_d = DONE;
        else                   col_cnt_d = col_cnt_q + 2'd1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      state_reg_q <= '0;
      key_reg_q   <= '0;
      res_reg_q   <= '0;
`ifdef CLM_MC_LAST_ROUND_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      state_reg_q <= state_reg_d;
      key_reg_q   <= key_reg_d;
      res_reg_q   <= res_reg_d;
`ifdef CLM_MC_LAST_ROUND_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_clm_mixcol_addkey_stage.sv
// Directed/randomized bench for clm_mixcol_addkey_stage against a byte-level AES reference.
module tb_clm_mixcol_addkey_stage;
  import clm_mixcol_addkey_stage_pkg::*;

  typedef logic [15:0][7:0] blk_t;  // clear state, byte index 4*col+row

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, rand_req, out_valid, out_ready;
  state_matrix_t in_state, in_key, out_state;
  rand_vect_t    random_vect;
  mm_matrix_t    L;
  mc_m_matrix_t  B_ext_MC;
  mn_matrix_t    MC;
`ifdef CLM_MC_LAST_ROUND_EN
  logic          last_round;
`endif

  int errors = 0;
  int checks = 0;

  clm_mixcol_addkey_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .in_key      (in_key),
`ifdef CLM_MC_LAST_ROUND_EN
    .last_round  (last_round),
`endif
    .random_vect (random_vect),
    .rand_req    (rand_req),
    .L           (L),
    .B_ext_MC    (B_ext_MC),
    .MC          (MC),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic blk_t ref_mix(input blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = xt(s[4*c+r]) ^ xt(s[4*c+(r+1)%4]) ^ s[4*c+(r+1)%4]
                 ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
    return o;
  endfunction

  function automatic blk_t hx(input logic [127:0] x);
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = x[127-8*i -: 8];
    return b;
  endfunction

  function automatic blk_t rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic state_matrix_t enc(input blk_t v);
    state_matrix_t m;
    logic [7:0] acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = v[4*c+r];
        for (int s = 0; s < NSH-1; s++) begin
          m[c][r][s] = 8'($urandom);
          acc ^= m[c][r][s];
        end
        m[c][r][NSH-1] = acc;
      end
    return m;
  endfunction

  function automatic blk_t dec(input state_matrix_t m);
    blk_t b;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        b[4*c+r] = 8'h00;
        for (int s = 0; s < NSH; s++) b[4*c+r] ^= m[c][r][s];
      end
    return b;
  endfunction

  function automatic rand_vect_t rnd_vect();
    rand_vect_t v;
    for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one state, follows it through MIX and stops at the negedge of the DONE cycle.
  task automatic run_state(input blk_t sv, input blk_t kv, input blk_t exp,
                           input bit zero_rand, input bit exp_rreq, input string tag);
    bit got = 0;
    in_state = enc(sv);
    in_key   = enc(kv);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) chk({tag, "_accept_timeout"}, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    random_vect = zero_rand ? '0 : rnd_vect();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("%s_rreq_c%0d", tag, c), rand_req, exp_rreq);
      chk($sformatf("%s_ov_early_c%0d", tag, c), out_valid, 1'b0);
      @(posedge clk); #1;
      random_vect = zero_rand ? '0 : rnd_vect();
    end
    @(negedge clk);
    chk({tag, "_ov_t5"}, out_valid, 1'b1);
    chk({tag, "_data"}, dec(out_state), exp);
  endtask

  initial begin
    blk_t sv, kv, ex;
    int acc_cnt, rreq_cnt, gap_bad, last_acc, rst_ov;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_state = '0; in_key = '0; random_vect = '0;
`ifdef CLM_MC_LAST_ROUND_EN
    last_round = 1'b0;
`endif
    for (int c = 0; c < 8; c++) begin
      logic [7:0] u, y;
      u = 8'(1 << c);
      y = xt(u);
      for (int r = 0; r < 8; r++) L[r][c] = y[r];
    end
    for (int s = 0; s < NSH; s++) begin
      B_ext_MC[s] = (s < 2) ? 2'b11 : 2'b00;
      MC[s]       = (s < 2) ? 2'b11 : 2'b00;
    end

    // reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_rand_req", rand_req, 1'b0);
    chk("rst_out_state", out_state, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);

    // single known column, zero randomness
    run_state(hx(128'hdb135345_00000000_00000000_00000000), '0,
              hx(128'h8e4da1bc_00000000_00000000_00000000), 1'b1, 1'b1, "fips_col");
    @(posedge clk); #1;
    @(negedge clk);
    chk("fips_col_t6_in_ready", in_ready, 1'b1);
    chk("fips_col_t6_out_valid", out_valid, 1'b0);

    // full round-1 state twice, different masks/randomness
    for (int k = 0; k < 2; k++) begin
      run_state(hx(128'hd4bf5d30e0b452aeb84111f11e2798e5),
                hx(128'ha0fafe1788542cb123a339392a6c7605),
                hx(128'ha49c7ff2689f352b6b5bea43026a5049), 1'b0, 1'b1,
                $sformatf("fips_full%0d", k));
      @(posedge clk); #1;
    end

    // random states vs reference
    for (int k = 0; k < 4; k++) begin
      sv = rnd_blk(); kv = rnd_blk();
      run_state(sv, kv, ref_mix(sv) ^ kv, 1'b0, 1'b1, $sformatf("rnd%0d", k));
      @(posedge clk); #1;
    end

    // backpressure
    out_ready = 1'b0;
    sv = rnd_blk(); kv = rnd_blk(); ex = ref_mix(sv) ^ kv;
    run_state(sv, kv, ex, 1'b0, 1'b1, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; random_vect = rnd_vect();
      @(negedge clk);
      chk($sformatf("bp_hold_data%0d", i), dec(out_state), ex);
      chk($sformatf("bp_hold_ov%0d", i), out_valid, 1'b1);
      chk($sformatf("bp_hold_in_ready%0d", i), in_ready, 1'b0);
      chk($sformatf("bp_hold_rreq%0d", i), rand_req, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_ov", out_valid, 1'b0);
    chk("bp_release_in_ready", in_ready, 1'b1);

    // reset in the second MIX cycle
    in_state = enc(rnd_blk()); in_key = enc(rnd_blk());
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; random_vect = rnd_vect();
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_gated", in_ready, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ov", out_valid, 1'b0);
    chk("midrst_idle", in_ready, 1'b1);
    chk("midrst_rreq", rand_req, 1'b0);
    rst_ov = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid) rst_ov++;
    end
    chk("midrst_no_ov", 32'(rst_ov), 32'd0);
    @(posedge clk); #1;
    sv = rnd_blk(); kv = rnd_blk();
    run_state(sv, kv, ref_mix(sv) ^ kv, 1'b0, 1'b1, "postrst");
    @(posedge clk); #1;

    // in_valid held high continuously
    sv = rnd_blk(); kv = rnd_blk(); ex = ref_mix(sv) ^ kv;
    in_state = enc(sv); in_key = enc(kv);
    in_valid = 1'b1;
    acc_cnt = 0; rreq_cnt = 0; gap_bad = 0; last_acc = -1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (last_acc >= 0 && i - last_acc != 6) gap_bad++;
        last_acc = i;
        acc_cnt++;
      end
      if (rand_req) rreq_cnt++;
      if (out_valid) chk($sformatf("busy_data_cyc%0d", i), dec(out_state), ex);
      @(posedge clk); #1;
      random_vect = rnd_vect();
    end
    in_valid = 1'b0;
    chk("busy_accepts", 32'(acc_cnt), 32'd4);
    chk("busy_gap_bad", 32'(gap_bad), 32'd0);
    chk("busy_rreq_cnt", 32'(rreq_cnt), 32'd16);
    @(posedge clk); #1;

`ifdef CLM_MC_LAST_ROUND_EN
    last_round = 1'b1;
    sv = rnd_blk(); kv = rnd_blk();
    run_state(sv, kv, sv ^ kv, 1'b0, 1'b0, "lastrnd");
    last_round = 1'b0;
    @(posedge clk); #1;
    sv = rnd_blk(); kv = rnd_blk();
    run_state(sv, kv, ref_mix(sv) ^ kv, 1'b0, 1'b1, "after_last");
    @(posedge clk); #1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
